// File: rtl/rx_chan_buffer.sv
// Per-channel receive sample buffer: each I/Q strobe becomes two 16-bit words (I then Q)
// in a circular RAM per channel. One reader pops words from the channel picked by rd_select.
module rx_chan_buffer #(
  parameter int NUM_CHAN = 2,
  parameter int ADDR_W   = 9
) (
  input  logic                      rxclk,
  input  logic                      reset,
  input  logic [NUM_CHAN:0]         ch_strobe,
  input  logic [16*(NUM_CHAN+1)-1:0] ch_i,
  input  logic [16*(NUM_CHAN+1)-1:0] ch_q,
  input  logic                      flush,
  input  logic                      clear_status,
  input  logic [3:0]                rd_select,
  input  logic                      chan_rdreq,
  output logic [15:0]               chan_fifodata,
  output logic [NUM_CHAN:0]         chan_empty,
  output logic [ADDR_W:0]           chan_usedw,
  output logic [NUM_CHAN:0]         overrun,
  output logic [NUM_CHAN:0]         underrun
);

  localparam int NCH   = NUM_CHAN + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]      MAX_SEL    = 4'(NUM_CHAN);
  // A sample is accepted only if both of its words fit.
  localparam logic [ADDR_W:0] ACCEPT_MAX = (ADDR_W+1)'(DEPTH - 2);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_Q    = 1'b1
  } wstate_e;

  wstate_e           wstate_q [NCH];
  wstate_e           wstate_d [NCH];
  logic [ADDR_W-1:0] wr_ptr_q [NCH];
  logic [ADDR_W-1:0] wr_ptr_d [NCH];
  logic [ADDR_W-1:0] rd_ptr_q [NCH];
  logic [ADDR_W-1:0] rd_ptr_d [NCH];
  logic [ADDR_W:0]   count_q  [NCH];
  logic [ADDR_W:0]   count_d  [NCH];
  logic [15:0]       qhold_q  [NCH];
  logic [15:0]       qhold_d  [NCH];
  logic [15:0]       wdata    [NCH];
  logic [15:0]       rd_word  [NCH];

  logic [NUM_CHAN:0] we;
  logic [NUM_CHAN:0] pop;
  logic [NUM_CHAN:0] overrun_set;
  logic [NUM_CHAN:0] underrun_set;
  logic [NUM_CHAN:0] overrun_q,  overrun_d;
  logic [NUM_CHAN:0] underrun_q, underrun_d;
  logic [15:0]       fifodata_q, fifodata_d;

  logic              sel_valid;
  logic [CH_W-1:0]   sel_idx;

  assign sel_valid = (rd_select <= MAX_SEL);
  assign sel_idx   = rd_select[CH_W-1:0];

  // Read side: a pop needs a valid selection and words already committed to the RAM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pop          = '0;
    underrun_set = '0;
    fifodata_d   = fifodata_q;
    if (chan_rdreq && sel_valid) begin
      if (count_q[sel_idx] == '0) begin
        underrun_set[sel_idx] = 1'b1;
      end else if (!flush) begin
        pop[sel_idx] = 1'b1;
        fifodata_d   = rd_word[sel_idx];
      end
    end
  end

  // Write sequencers: I goes in on the strobe cycle, the latched Q on the following one.
  always_comb begin
    overrun_set = '0;
    for (int c = 0; c < NCH; c++) begin
      wstate_d[c] = wstate_q[c];
      qhold_d[c]  = qhold_q[c];
      we[c]       = 1'b0;
      wdata[c]    = ch_i[16*c +: 16];
      case (wstate_q[c])
        W_IDLE: begin
          if (ch_strobe[c]) begin
            if (count_q[c] <= ACCEPT_MAX) begin
              we[c]       = 1'b1;
              qhold_d[c]  = ch_q[16*c +: 16];
              wstate_d[c] = W_Q;
            end else begin
              overrun_set[c] = 1'b1;
            end
          end
        end
        W_Q: begin
          we[c]       = 1'b1;
          wdata[c]    = qhold_q[c];
          wstate_d[c] = W_IDLE;
          if (ch_strobe[c]) overrun_set[c] = 1'b1;
        end
        default: wstate_d[c] = W_IDLE;
      endcase
      if (flush) begin
        we[c]       = 1'b0;
        wstate_d[c] = W_IDLE;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      if (flush) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        count_d[c]  = '0;
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c] + ADDR_W'(we[c]);
        rd_ptr_d[c] = rd_ptr_q[c] + ADDR_W'(pop[c]);
        count_d[c]  = count_q[c] + (ADDR_W+1)'(we[c]) - (ADDR_W+1)'(pop[c]);
      end
    end
  end

  // Sticky flags: a same-cycle set beats clear_status.
  always_comb begin
    overrun_d  = (clear_status ? '0 : overrun_q)  | overrun_set;
    underrun_d = (clear_status ? '0 : underrun_q) | underrun_set;
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        wstate_q[c] <= W_IDLE;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
        qhold_q[c]  <= '0;
      end
      overrun_q  <= '0;
      underrun_q <= '0;
      fifodata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      for (int c = 0; c < NCH; c++) begin
        wstate_q[c] <= wstate_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
        qhold_q[c]  <= qhold_d[c];
      end
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      fifodata_q <= fifodata_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ram
    logic [15:0] mem [DEPTH];

    // NOTE: RAM contents are deliberately not reset; pointers and counts alone define validity.
    always_ff @(posedge rxclk) begin
      if (we[g]) mem[wr_ptr_q[g]] <= wdata[g];
    end

    assign rd_word[g] = mem[rd_ptr_q[g]];
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      chan_empty[c] = (count_q[c] == '0);
    end
  end

  assign chan_usedw    = sel_valid ? count_q[sel_idx] : '0;
  assign chan_fifodata = fifodata_q;
  assign overrun       = overrun_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_rx_chan_buffer.sv
// Self-checking bench for rx_chan_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the channel buffers.
module tb_rx_chan_buffer;

  localparam int NUM_CHAN = 2;
  localparam int ADDR_W   = 9;
  localparam int NCH      = NUM_CHAN + 1;
  localparam int DEPTH    = 512;

  logic                 rxclk = 1'b0;
  logic                 reset;
  logic [NUM_CHAN:0]    ch_strobe;
  logic [16*NCH-1:0]    ch_i;
  logic [16*NCH-1:0]    ch_q;
  logic                 flush;
  logic                 clear_status;
  logic [3:0]           rd_select;
  logic                 chan_rdreq;
  logic [15:0]          chan_fifodata;
  logic [NUM_CHAN:0]    chan_empty;
  logic [ADDR_W:0]      chan_usedw;
  logic [NUM_CHAN:0]    overrun;
  logic [NUM_CHAN:0]    underrun;

  always #5 rxclk = ~rxclk;

  rx_chan_buffer #(.NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W)) dut (
    .rxclk        (rxclk),
    .reset        (reset),
    .ch_strobe    (ch_strobe),
    .ch_i         (ch_i),
    .ch_q         (ch_q),
    .flush        (flush),
    .clear_status (clear_status),
    .rd_select    (rd_select),
    .chan_rdreq   (chan_rdreq),
    .chan_fifodata(chan_fifodata),
    .chan_empty   (chan_empty),
    .chan_usedw   (chan_usedw),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model: one word queue per channel; a pending Q waits one cycle before joining its queue.
  logic [15:0]    mq [NCH][$];
  bit             pend   [NCH];
  logic [15:0]    pend_q [NCH];
  logic [15:0]    m_data;
  logic [NCH-1:0] m_ovr;
  logic [NCH-1:0] m_udr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      pend[c]   = 1'b0;
      pend_q[c] = '0;
    end
    m_data = '0;
    m_ovr  = '0;
    m_udr  = '0;
  endtask

  task automatic model_step();
    int             sz [NCH];
    logic [NCH-1:0] oset;
    logic [NCH-1:0] uset;
    oset = '0;
    uset = '0;
    for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
    if (chan_rdreq && rd_select <= NUM_CHAN) begin
      int s;
      s = int'(rd_select);
      if (sz[s] == 0) uset[s] = 1'b1;
      else if (!flush) m_data = mq[s].pop_front();
    end
    for (int c = 0; c < NCH; c++) begin
      if (pend[c]) begin
        mq[c].push_back(pend_q[c]);
        pend[c] = 1'b0;
        if (ch_strobe[c]) oset[c] = 1'b1;
      end else if (ch_strobe[c]) begin
        if (DEPTH - sz[c] >= 2) begin
          mq[c].push_back(ch_i[16*c +: 16]);
          pend[c]   = 1'b1;
          pend_q[c] = ch_q[16*c +: 16];
        end else begin
          oset[c] = 1'b1;
        end
      end
      if (flush) begin
        mq[c].delete();
        pend[c] = 1'b0;
      end
    end
    m_ovr = (clear_status ? '0 : m_ovr) | oset;
    m_udr = (clear_status ? '0 : m_udr) | uset;
  endtask

  task automatic compare();
    logic [NCH-1:0] exp_empty;
    int             exp_used;
    for (int c = 0; c < NCH; c++) exp_empty[c] = (mq[c].size() == 0);
    exp_used = (rd_select <= NUM_CHAN) ? mq[rd_select].size() : 0;
    check("fifodata", 32'(chan_fifodata), 32'(m_data));
    check("empty",    32'(chan_empty),    32'(exp_empty));
    check("usedw",    32'(chan_usedw),    32'(exp_used));
    check("overrun",  32'(overrun),       32'(m_ovr));
    check("underrun", 32'(underrun),      32'(m_udr));
  endtask

  initial begin
    forever begin
      @(posedge rxclk);
      if (!reset) model_step();
      #2;
      if (check_en) compare();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge rxclk);
  endtask

  task automatic idle_inputs();
    ch_strobe    = '0;
    flush        = 1'b0;
    clear_status = 1'b0;
    chan_rdreq   = 1'b0;
  endtask

  task automatic strobe(input int c, input logic [15:0] i_w, input logic [15:0] q_w);
    ch_strobe[c]      = 1'b1;
    ch_i[16*c +: 16]  = i_w;
    ch_q[16*c +: 16]  = q_w;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fifodata"}, 32'(chan_fifodata), 32'h0);
    check({tag, "_empty"},    32'(chan_empty),    32'h7);
    check({tag, "_usedw"},    32'(chan_usedw),    32'h0);
    check({tag, "_overrun"},  32'(overrun),       32'h0);
    check({tag, "_underrun"}, 32'(underrun),      32'h0);
  endtask

  initial begin
    idle_inputs();
    ch_i      = '0;
    ch_q      = '0;
    rd_select = '0;
    reset     = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    cyc(3);
    check_reset_values("reset");
    reset    = 1'b0;
    check_en = 1'b1;

    // 1: single sample on ch0, read back in order
    rd_select = 4'd0;
    strobe(0, 16'h1111, 16'h2222);
    cyc(); idle_inputs(); cyc();
    check("t1_usedw", 32'(chan_usedw), 32'd2);
    chan_rdreq = 1'b1;
    cyc();
    check("t1_rd_i", 32'(chan_fifodata), 32'h1111);
    cyc();
    check("t1_rd_q", 32'(chan_fifodata), 32'h2222);
    chan_rdreq = 1'b0;
    check("t1_empty", 32'(chan_empty[0]), 32'd1);

    // 2: fill ch1 to full, then overflow
    rd_select = 4'd1;
    for (int k = 0; k < 256; k++) begin
      strobe(1, 16'(2*k), 16'(2*k + 1));
      cyc(); idle_inputs(); cyc(3);
    end
    check("t2_usedw_full", 32'(chan_usedw), 32'd512);
    check("t2_not_empty",  32'(chan_empty[1]), 32'd0);
    check("t2_no_overrun", 32'(overrun[1]), 32'd0);
    strobe(1, 16'hDEAD, 16'hBEEF);
    cyc(); idle_inputs(); cyc(2);
    check("t2_usedw_stays", 32'(chan_usedw), 32'd512);
    check("t2_overrun",     32'(overrun[1]), 32'd1);
    clear_status = 1'b1;
    cyc(); idle_inputs();
    check("t2_overrun_clr", 32'(overrun[1]), 32'd0);
    flush = 1'b1;
    cyc(); idle_inputs();
    check("t2_flush_usedw", 32'(chan_usedw), 32'd0);

    // 3: simultaneous strobes on every channel
    for (int c = 0; c < NCH; c++) strobe(c, 16'h3000 + 16'(c), 16'h4000 + 16'(c));
    cyc(); idle_inputs(); cyc();
    for (int c = 0; c < NCH; c++) begin
      rd_select = 4'(c);
      #1;
      check("t3_usedw", 32'(chan_usedw), 32'd2);
      chan_rdreq = 1'b1;
      cyc();
      check("t3_rd_i", 32'(chan_fifodata), 32'h3000 + 32'(c));
      cyc();
      check("t3_rd_q", 32'(chan_fifodata), 32'h4000 + 32'(c));
      chan_rdreq = 1'b0;
    end

    // 4: back-to-back strobes on ch2 drop the second sample
    strobe(2, 16'h5555, 16'h6666);
    cyc();
    strobe(2, 16'h7777, 16'h8888);
    cyc(); idle_inputs(); cyc();
    rd_select = 4'd2;
    #1;
    check("t4_usedw",   32'(chan_usedw), 32'd2);
    check("t4_overrun", 32'(overrun[2]), 32'd1);
    chan_rdreq = 1'b1;
    cyc();
    check("t4_rd_i", 32'(chan_fifodata), 32'h5555);
    cyc();
    check("t4_rd_q", 32'(chan_fifodata), 32'h6666);
    chan_rdreq   = 1'b0;
    clear_status = 1'b1;
    cyc(); idle_inputs();

    // 5: underrun, out-of-range select, and set-beats-clear
    rd_select  = 4'd0;
    chan_rdreq = 1'b1;
    cyc(); idle_inputs();
    check("t5_underrun",  32'(underrun[0]), 32'd1);
    check("t5_data_hold", 32'(chan_fifodata), 32'h6666);
    rd_select  = 4'd7;
    chan_rdreq = 1'b1;
    #1;
    check("t5_bad_usedw", 32'(chan_usedw), 32'd0);
    cyc(); idle_inputs();
    check("t5_bad_noflag", 32'(underrun), 32'h1);
    check("t5_bad_hold",   32'(chan_fifodata), 32'h6666);
    rd_select    = 4'd1;
    chan_rdreq   = 1'b1;
    clear_status = 1'b1;
    cyc(); idle_inputs();
    check("t5_set_wins", 32'(underrun), 32'h2);
    clear_status = 1'b1;
    cyc(); idle_inputs();
    check("t5_cleared", 32'(underrun), 32'h0);

    // 6: ch0 steady state across several pointer wraps, with a flush and an async reset
    rd_select = 4'd0;
    for (int i = 0; i < 1800; i++) begin
      if (i == 1200) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("t6_async");
        cyc();
        reset = 1'b0;
      end
      if (i % 2 == 0 && i < 1750) strobe(0, 16'($urandom), 16'($urandom));
      chan_rdreq = (mq[0].size() > 0);
      if (i == 600) flush = 1'b1;
      cyc(); idle_inputs();
      if (i == 600) check("t6_flush_usedw", 32'(chan_usedw), 32'd0);
    end
    cyc(4);

    // random traffic on all channels
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) ch_strobe[c] = ($urandom_range(2) == 0);
      ch_i         = 48'({$urandom(), $urandom()});
      ch_q         = 48'({$urandom(), $urandom()});
      chan_rdreq   = 1'($urandom_range(1));
      rd_select    = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
      flush        = ($urandom_range(799) == 0);
      clear_status = ($urandom_range(49) == 0);
      cyc();
    end
    idle_inputs();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
